// File: rtl/pe_ws_dbuf_if.sv
// Bundle of the systolic PE's dataflow and weight-chain signals.
// The master side drives west/north inputs; the slave side is the PE itself.
interface pe_ws_dbuf_if #(
  parameter int unsigned A_WIDTH   = 8,
  parameter int unsigned W_WIDTH   = 8,
  parameter int unsigned ACC_WIDTH = 22
);
  logic                 en;
  logic                 in_valid;
  logic [A_WIDTH-1:0]   a_in;
  logic [ACC_WIDTH-1:0] b_in;
  logic                 swap_in;
  logic                 w_load;
  logic [W_WIDTH-1:0]   w_in;
  logic [A_WIDTH-1:0]   a_out;
  logic                 a_valid_out;
  logic                 swap_out;
  logic [ACC_WIDTH-1:0] psum_out;
  logic                 psum_valid;
  logic [W_WIDTH-1:0]   w_out;

  modport master (
    output en, in_valid, a_in, b_in, swap_in, w_load, w_in,
    input  a_out, a_valid_out, swap_out, psum_out, psum_valid, w_out
  );

  modport slave (
    input  en, in_valid, a_in, b_in, swap_in, w_load, w_in,
    output a_out, a_valid_out, swap_out, psum_out, psum_valid, w_out
  );
endinterface

// File: rtl/pe_ws_dbuf.sv
// Weight-stationary MAC PE with double-buffered weights and a swap token.
// Define PE_SAT_EN for a saturating accumulate and a sticky ovf output.
module pe_ws_dbuf #(
  parameter int unsigned A_WIDTH   = 8,
  parameter int unsigned W_WIDTH   = 8,
  parameter int unsigned ACC_WIDTH = 22,
  parameter int unsigned A_DELAY   = 2
) (
  input  logic          clk,
  input  logic          rst,
`ifdef PE_SAT_EN
  output logic          ovf,
`endif
  pe_ws_dbuf_if.slave   bus
);

  localparam int unsigned PWidth = A_WIDTH + W_WIDTH;

  if (ACC_WIDTH < PWidth) begin : g_bad_acc
    $error("ACC_WIDTH must be >= A_WIDTH + W_WIDTH");
  end
  if (A_DELAY < 1) begin : g_bad_delay
    $error("A_DELAY must be >= 1");
  end

  logic [W_WIDTH-1:0]   shadow_q, shadow_d, active_q, active_d;
  logic                 swap_q, swap_d;
  logic [ACC_WIDTH-1:0] prod_q, prod_d, b_q, b_d, psum_q, psum_d;
  logic                 v1_q, v1_d, pv_q, pv_d;
  logic [A_WIDTH-1:0]   a_pipe_q [A_DELAY];
  logic [A_WIDTH-1:0]   a_pipe_d [A_DELAY];
  logic [A_DELAY-1:0]   av_pipe_q, av_pipe_d;

  logic signed [PWidth-1:0]    prod_full;
  logic signed [ACC_WIDTH-1:0] prod_ext;
  logic [ACC_WIDTH-1:0]        sum_res;

`ifdef PE_SAT_EN
  logic                 ovf_q, ovf_d;
  logic [ACC_WIDTH:0]   sum_ext;
  logic                 sum_ovf;
`endif

  always_comb begin
    prod_full = $signed(bus.a_in) * $signed(active_q);
    prod_ext  = prod_full;
`ifdef PE_SAT_EN
    // One guard bit: overflow iff the two top bits of the extended sum differ.
    sum_ext = {b_q[ACC_WIDTH-1], b_q} + {prod_q[ACC_WIDTH-1], prod_q};
    sum_ovf = sum_ext[ACC_WIDTH] ^ sum_ext[ACC_WIDTH-1];
    if (sum_ovf) begin
      sum_res = sum_ext[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                   : {1'b0, {(ACC_WIDTH-1){1'b1}}};
    end else begin
      sum_res = sum_ext[ACC_WIDTH-1:0];
    end
`else
    sum_res = b_q + prod_q;
`endif
  end

  always_comb begin
    shadow_d  = shadow_q;
    active_d  = active_q;
    swap_d    = swap_q;
    prod_d    = prod_q;
    b_d       = b_q;
    v1_d      = v1_q;
    psum_d    = psum_q;
    pv_d      = pv_q;
    a_pipe_d  = a_pipe_q;
    av_pipe_d = av_pipe_q;
`ifdef PE_SAT_EN
    ovf_d     = ovf_q;
`endif

    // The weight chain shifts regardless of en so it can preload during stalls.
    if (bus.w_load) shadow_d = bus.w_in;

    if (bus.en) begin
      swap_d = bus.swap_in;
      if (bus.swap_in) active_d = shadow_q;
      prod_d = bus.in_valid ? prod_ext : '0;
      b_d    = bus.in_valid ? bus.b_in : '0;
      v1_d   = bus.in_valid;
      psum_d = sum_res;
      pv_d   = v1_q;
      a_pipe_d[0]  = bus.in_valid ? bus.a_in : '0;
      av_pipe_d[0] = bus.in_valid;
      for (int i = 1; i < int'(A_DELAY); i++) begin
        a_pipe_d[i]  = a_pipe_q[i-1];
        av_pipe_d[i] = av_pipe_q[i-1];
      end
`ifdef PE_SAT_EN
      if (v1_q && sum_ovf) ovf_d = 1'b1;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q  <= '0;
      active_q  <= '0;
      swap_q    <= 1'b0;
      prod_q    <= '0;
      b_q       <= '0;
      v1_q      <= 1'b0;
      psum_q    <= '0;
      pv_q      <= 1'b0;
      av_pipe_q <= '0;
      for (int i = 0; i < int'(A_DELAY); i++) a_pipe_q[i] <= '0;
`ifdef PE_SAT_EN
      ovf_q     <= 1'b0;
`endif
    end else begin
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      swap_q    <= swap_d;
      prod_q    <= prod_d;
      b_q       <= b_d;
      v1_q      <= v1_d;
      psum_q    <= psum_d;
      pv_q      <= pv_d;
      av_pipe_q <= av_pipe_d;
      a_pipe_q  <= a_pipe_d;
`ifdef PE_SAT_EN
      ovf_q     <= ovf_d;
`endif
    end
  end

  assign bus.a_out       = a_pipe_q[A_DELAY-1];
  assign bus.a_valid_out = av_pipe_q[A_DELAY-1];
  assign bus.swap_out    = swap_q;
  assign bus.psum_out    = psum_q;
  assign bus.psum_valid  = pv_q;
  assign bus.w_out       = shadow_q;
`ifdef PE_SAT_EN
  assign ovf             = ovf_q;
`endif

endmodule

// File: tb/tb_pe_ws_dbuf.sv
// Scoreboard bench for pe_ws_dbuf: a behavioural model queues expected psum/activation
// results per enabled cycle and compares them as they emerge from the pipeline.
module tb_pe_ws_dbuf;
  localparam int AW   = 8;
  localparam int WW   = 8;
  localparam int ACCW = 22;
  localparam int AD   = 2;
  localparam longint AccMax = (64'sd1 <<< (ACCW - 1)) - 1;
  localparam longint AccMin = -(64'sd1 <<< (ACCW - 1));

  logic clk = 1'b0;
  logic rst;
`ifdef PE_SAT_EN
  logic ovf;
`endif

  pe_ws_dbuf_if #(.A_WIDTH(AW), .W_WIDTH(WW), .ACC_WIDTH(ACCW)) bus ();

  pe_ws_dbuf #(.A_WIDTH(AW), .W_WIDTH(WW), .ACC_WIDTH(ACCW), .A_DELAY(AD)) dut (
    .clk (clk),
    .rst (rst),
`ifdef PE_SAT_EN
    .ovf (ovf),
`endif
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {bit v; longint val; bit sat;} exp_t;
  exp_t   pq[$];
  exp_t   aq[$];
  int     n_checks = 0;
  int     n_fail   = 0;
  longint shadow_m, active_m, cur_psum, cur_a;
  bit     swap_m, cur_pv, cur_av, ovf_m;

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    pq.delete();
    aq.delete();
    shadow_m = 0; active_m = 0; cur_psum = 0; cur_a = 0;
    swap_m = 0; cur_pv = 0; cur_av = 0; ovf_m = 0;
  endtask

  // Drive one cycle of stimulus, advance the model on the edge, then compare outputs.
  task automatic step(input bit r, input bit e, input bit v, input int a, input int b,
                      input bit sw, input bit wl, input int w, input string tag);
    exp_t   pe, ae;
    longint raw;
    bit     sat;
    rst = r; bus.en = e; bus.in_valid = v; bus.a_in = a[AW-1:0]; bus.b_in = b[ACCW-1:0];
    bus.swap_in = sw; bus.w_load = wl; bus.w_in = w[WW-1:0];
    @(posedge clk);
    #1;
    if (r) begin
      model_reset();
    end else begin
      if (e) begin
        raw = longint'(b) + longint'(a) * active_m;
        sat = 0;
`ifdef PE_SAT_EN
        if (raw > AccMax) begin raw = AccMax; sat = 1; end
        if (raw < AccMin) begin raw = AccMin; sat = 1; end
`else
        raw = raw & ((64'sd1 <<< ACCW) - 1);
        if (raw > AccMax) raw = raw - (64'sd1 <<< ACCW);
`endif
        pe.v = v; pe.val = v ? raw : 0; pe.sat = v & sat;
        ae.v = v; ae.val = v ? a : 0; ae.sat = 0;
        pq.push_back(pe);
        aq.push_back(ae);
        while (pq.size() >= 2) begin
          pe = pq.pop_front();
          cur_psum = pe.val; cur_pv = pe.v;
          if (pe.sat) ovf_m = 1;
        end
        while (aq.size() >= AD) begin
          ae = aq.pop_front();
          cur_a = ae.val; cur_av = ae.v;
        end
        swap_m = sw;
        if (sw) active_m = shadow_m;
      end
      if (wl) shadow_m = w;
    end
    check_eq({tag, ".psum"},   $signed(bus.psum_out), cur_psum);
    check_eq({tag, ".pvalid"}, bus.psum_valid, cur_pv);
    check_eq({tag, ".a_out"},  $signed(bus.a_out), cur_a);
    check_eq({tag, ".avalid"}, bus.a_valid_out, cur_av);
    check_eq({tag, ".swap"},   bus.swap_out, swap_m);
    check_eq({tag, ".w_out"},  $signed(bus.w_out), shadow_m);
`ifdef PE_SAT_EN
    check_eq({tag, ".ovf"},    ovf, ovf_m);
`endif
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) step(0, 1, 0, 0, 0, 0, 0, 0, tag);
  endtask

  initial begin
    model_reset();
    step(1, 0, 0, 0, 0, 0, 0, 0, "reset");
    step(1, 1, 1, 5, 5, 1, 1, 7, "reset2");

    // Preload weight 3, swap with no data, then one valid sample.
    step(0, 1, 0, 0, 0, 0, 1, 3, "preload");
    step(0, 1, 0, 0, 0, 1, 0, 0, "swap");
    step(0, 1, 1, 5, 10, 0, 0, 0, "a5b10");
    idle(4, "flush1");

    // Double buffer: shadow -2 loads while streaming; swap aligned with a=3.
    step(0, 1, 1, 1, 0, 0, 1, -2, "db1");
    step(0, 1, 1, 2, 0, 0, 0, 0, "db2");
    step(0, 1, 1, 3, 0, 1, 0, 0, "db3");
    step(0, 1, 1, 4, 0, 0, 0, 0, "db4");
    idle(3, "flush2");

    // Swap and load together: active gets old shadow (2), shadow gets 5.
    step(0, 1, 0, 0, 0, 0, 1, 2, "ld2");
    step(0, 1, 0, 0, 0, 1, 1, 5, "swapld");
    step(0, 1, 1, 7, 1, 0, 0, 0, "st_a7");
    step(0, 0, 1, 9, 9, 1, 0, 0, "stall1");
    step(0, 0, 0, 0, 0, 0, 1, 6, "stall2");
    step(0, 0, 1, 3, 3, 1, 0, 0, "stall3");
    step(0, 1, 1, 7, 1, 0, 0, 0, "st_a7b");
    step(0, 0, 0, 0, 0, 0, 0, 0, "stall4");
    step(0, 0, 0, 0, 0, 0, 0, 0, "stall5");
    step(0, 0, 0, 0, 0, 0, 0, 0, "stall6");
    idle(4, "flush3");

    // Invalid gaps with w=4.
    step(0, 1, 0, 0, 0, 0, 1, 4, "ld4");
    step(0, 1, 0, 0, 0, 1, 0, 0, "sw4");
    for (int i = 0; i < 6; i++) step(0, 1, i % 2 == 0, 4, 100, 0, 0, 0, "gap");
    idle(3, "flush4");

    // Accumulator boundary: b = max positive, product = 1.
    step(0, 1, 0, 0, 0, 0, 1, 1, "ld1");
    step(0, 1, 0, 0, 0, 1, 0, 0, "sw1");
    step(0, 1, 1, 1, 2097151, 0, 0, 0, "ovf");
    step(0, 1, 1, -1, -2097152, 0, 0, 0, "neg_ovf");
    idle(4, "flush5");

    // Reset while psum_valid is high, then active weight must be 0.
    step(0, 1, 1, 1, 0, 0, 0, 0, "ms1");
    step(0, 1, 1, 2, 0, 0, 0, 0, "ms2");
    check_eq("ms.pvalid_high", bus.psum_valid, 1);
    step(1, 1, 1, 3, 0, 0, 0, 0, "mid_rst");
    step(0, 1, 1, 9, 7, 0, 0, 0, "a9");
    idle(3, "flush6");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/pe_ws_dbuf.md
Name: pe_ws_dbuf

Overview:
- Second-generation weight-stationary systolic processing element for the LeNet conv/FC array.
- Computes psum_out = b_in + a_in*weight each valid cycle.
- Forwards activations east with a configurable skew delay and partial sums south.
- Double-buffered weights: the next layer's weights shift in through a shadow register while the current layer computes. A swap token propagates with the data wavefront.

Parameters:
- A_WIDTH, 8, signed activation width.
- W_WIDTH, 8, signed weight width.
- ACC_WIDTH, 22, signed partial-sum width; must be >= A_WIDTH+W_WIDTH (elaboration error otherwise).
- A_DELAY, 2, activation pass-through latency in cycles; must be >= 1.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- en  in  1  datapath advance enable; 0 = stall.
- in_valid  in  1  qualifies a_in and b_in.
- a_in  in  A_WIDTH  activation from west.
- b_in  in  ACC_WIDTH  partial sum from north.
- swap_in  in  1  swap token from west.
- w_load  in  1  shift-enable for the weight chain.
- w_in  in  W_WIDTH  weight from north neighbour's chain.
- a_out  out  A_WIDTH  activation to east.
- a_valid_out  out  1  valid aligned with a_out.
- swap_out  out  1  swap token to east.
- psum_out  out  ACC_WIDTH  partial sum to south.
- psum_valid  out  1  valid aligned with psum_out.
- w_out  out  W_WIDTH  shadow weight to south neighbour's chain.

Behaviour:
- Reset (rst=1 at a clock edge) clears all state and all outputs to 0, including the shadow weight, the active weight and the pipelines. Reset mid-operation discards in-flight data; there is no partial flush.
- Weight chain:
  - On w_load=1, shadow <= w_in. w_out is the shadow register, giving chain latency 1 per PE.
  - The chain is independent of en, so it loads while the datapath is stalled.
- Swap:
  - On en=1 and swap_in=1: active <= shadow, and swap_out <= 1 at the next edge.
  - On en=1 and swap_in=0: swap_out <= 0.
  - On en=0: swap_in is ignored and swap_out holds.
  - w_load and swap in the same cycle: active takes the old shadow; shadow takes w_in.
- Swap/data alignment: a sample accepted in the same cycle as swap_in multiplies with the OLD active weight. The new weight applies from the next accepted sample.
- Datapath, when en=1:
  - Stage 1: prod_r <= a_in*active, sign-extended to ACC_WIDTH; b_r <= b_in; v1 <= in_valid. When in_valid=0, prod_r and b_r load 0.
  - Stage 2: psum_out <= b_r + prod_r; psum_valid <= v1.
  - psum latency is exactly 2 enabled cycles.
  - a_in and in_valid pass through an A_DELAY-deep shift register to a_out and a_valid_out. Invalid slots carry a=0.
- Stall (en=0): every datapath register, swap_out and all valids hold their values. Outputs remain stable.
- Arithmetic:
  - The product is full precision (A_WIDTH+W_WIDTH bits), signed two's complement.
  - The addition wraps modulo 2^ACC_WIDTH unless PE_SAT_EN is defined.

Optional Feature:
- Macro PE_SAT_EN.
- Defined:
  - Stage-2 addition saturates to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1].
  - An extra output port ovf (1 bit) is added. It is sticky and set when a valid addition saturates.
  - ovf is cleared only by rst.
- Undefined: wraparound addition; no ovf port.

Test Plan:
- Reset/preload: assert rst, then shift weight 3 with w_load, then swap_in=1 with in_valid=0. Then send a_in=5, b_in=10 valid. Expect psum_out=25 with psum_valid=1 two cycles later. Expect a_out=5 A_DELAY cycles later; w_out=3; swap_out pulse one cycle after swap_in.
- Double buffer: active=3; load shadow=-2 while streaming a=1,2,3 (b=0). Assert swap_in together with a=3, then send a=4. Expect psums 3, 6, 9, -8.
- Stall: stream a=7, w=2, b=1; drop en for 3 cycles mid-pipeline. Expect psum_out=15 frozen, no duplicate valid, and correct result after en returns. Pulse w_load during the stall; expect the shadow to update.
- Invalid gaps: alternate in_valid 1/0 with a=4, w=4, b=100. Expect psum 116/valid 1, then 0/valid 0, alternating. Expect a_valid_out to mirror with delay A_DELAY.
- Overflow: ACC_WIDTH=22, b_in=2097151, a=1, w=1. Without PE_SAT_EN, expect psum_out=-2097152. With PE_SAT_EN, expect psum_out=2097151 and ovf=1, held until rst.
- Reset mid-stream: assert rst while psum_valid=1. The next cycle must show all outputs 0 and active weight 0; a subsequent valid a=9 gives psum=b_in.
